// File: rtl/nic_inject_queue.sv
// nic_inject_queue: per-node injection stage between a packet generator and the
// router's local injection port. Incoming single-flit packets get this node's
// source coordinates and a 12-bit sequence number stamped into the header. They
// are buffered in a FIFO and offered to the router with a req/ack handshake. An
// end-of-simulation request stops intake, drains the FIFO and then parks in DONE.
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   end_sim        level; stop accepting, drain, then raise drain_done
//   my_x, my_y     static node coordinates stamped into src_x/src_y
//   gen_data/push  generator packet and valid; gen_push_ack = accepted this cycle
//   net_data/req   head packet and valid to the router; net_ack pops it
//   q_empty, count FIFO status
//   sent_cnt       packets delivered to the router (wraps)
//   drain_done     high in the DONE state
module nic_inject_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             end_sim,
  input  logic [2:0]       my_x,
  input  logic [2:0]       my_y,
  input  logic [63:0]      gen_data,
  input  logic             gen_push,
  output logic             gen_push_ack,
  output logic [63:0]      net_data,
  output logic             net_req,
  input  logic             net_ack,
  output logic             q_empty,
  output logic [PTR_W:0]   count,
  output logic [31:0]      sent_cnt,
  output logic             drain_done
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [11:0]      r_seq;
  logic [31:0]      r_sent;
  logic [1:0]       r_state;

  logic [1:0]  w_state_nxt;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic [63:0] w_stamped;

  assign w_full = (r_count == FULL_CNT);

  // Gated by reset so nothing is acknowledged while reset is held.
  assign gen_push_ack = gen_push & (r_state == ST_RUN) & ~w_full & ~end_sim & ~reset;
  assign w_push       = gen_push_ack;

  assign net_req  = (r_count != '0);
  assign net_data = r_mem[r_rd_ptr];
  assign w_pop    = net_req & net_ack;

  // dst kept, src overwritten with this node, seq replaces bits 51:40.
  assign w_stamped = {gen_data[63:58], my_x, my_y, r_seq, gen_data[39:0]};

  assign q_empty    = (r_count == '0);
  assign count      = r_count;
  assign sent_cnt   = r_sent;
  assign drain_done = (r_state == ST_DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (end_sim) w_state_nxt = ST_DRAIN;
      // Evaluated on the registered count, so an already-empty FIFO still
      // spends one cycle here.
      ST_DRAIN: if (r_count == '0) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_seq    <= '0;
      r_sent   <= '0;
      r_state  <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_seq    <= r_seq + 12'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_sent   <= r_sent + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed behind a valid count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_stamped;
  end

endmodule

// File: tb/tb_nic_inject_queue.sv
module tb_nic_inject_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           end_sim;
  logic [2:0]     my_x;
  logic [2:0]     my_y;
  logic [63:0]    gen_data;
  logic           gen_push;
  logic           gen_push_ack;
  logic [63:0]    net_data;
  logic           net_req;
  logic           net_ack;
  logic           q_empty;
  logic [PTR_W:0] count;
  logic [31:0]    sent_cnt;
  logic           drain_done;

  always #5 clk = ~clk;

  nic_inject_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .end_sim      (end_sim),
    .my_x         (my_x),
    .my_y         (my_y),
    .gen_data     (gen_data),
    .gen_push     (gen_push),
    .gen_push_ack (gen_push_ack),
    .net_data     (net_data),
    .net_req      (net_req),
    .net_ack      (net_ack),
    .q_empty      (q_empty),
    .count        (count),
    .sent_cnt     (sent_cnt),
    .drain_done   (drain_done)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb[$];
  logic [11:0] seq_m;
  logic [31:0] sent_m;
  int          pops_m;
  bit          draining;
  bit          last_ack;
  logic [63:0] last_pop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] stamp(input logic [63:0] d, input logic [11:0] s);
    return {d[63:58], my_x, my_y, s, d[39:0]};
  endfunction

  function automatic logic [63:0] pkt(input int p);
    return {6'h2A, 18'h0, 40'hCAFE000000 | 40'(p)};
  endfunction

  // One clock: sample mid-cycle, score against the model, then advance.
  task automatic cycle();
    logic exp_ack;
    logic exp_pop;
    #4;
    if (reset) begin
      chk("ack_in_reset", gen_push_ack, 1'b0);
      @(posedge clk); #1;
      sb.delete();
      seq_m = 0; sent_m = 0; pops_m = 0; draining = 0; last_ack = 0;
    end else begin
      exp_ack = gen_push && !end_sim && !draining && (sb.size() < DEPTH);
      exp_pop = net_ack && (sb.size() > 0);
      chk("gen_push_ack", gen_push_ack, exp_ack);
      chk("net_req", net_req, sb.size() != 0);
      chk("count", count, sb.size());
      chk("q_empty", q_empty, sb.size() == 0);
      chk("sent_cnt", sent_cnt, sent_m);
      last_ack = exp_ack;
      if (exp_pop) begin
        chk("net_data", net_data, sb.pop_front());
        last_pop = net_data;
        pops_m++;
        sent_m++;
      end
      if (exp_ack) begin
        sb.push_back(stamp(gen_data, seq_m));
        seq_m++;
      end
      if (end_sim) draining = 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1; end_sim = 0; gen_push = 1; net_ack = 1;
    cycle();
    cycle();
    reset = 0; gen_push = 0; net_ack = 0;
  endtask

  initial begin
    int p;
    int zero_at;
    int done_at;
    bit got;
    my_x = 3'd3; my_y = 3'd5;
    gen_data = '0; gen_push = 0; net_ack = 0; end_sim = 0; reset = 1;

    // Reset state
    do_reset();
    chk("rst_net_req", net_req, 1'b0);
    chk("rst_q_empty", q_empty, 1'b1);
    chk("rst_drain_done", drain_done, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_sent_cnt", sent_cnt, 0);

    // Single packet, one-cycle latency, stamped header
    gen_data = 64'hE000_0000_0000_00AB; gen_push = 1; net_ack = 1;
    cycle();
    gen_push = 0;
    chk("first_net_req", net_req, 1'b1);
    chk("first_net_data", net_data, 64'hE1D0_0000_0000_00AB);
    cycle();
    chk("first_sent_cnt", sent_cnt, 1);
    chk("first_q_empty", q_empty, 1'b1);

    // Fill to full with no acks, then full-with-pop behaviour
    do_reset();
    p = 0;
    for (int i = 0; i < 10; i++) begin
      gen_data = pkt(p); gen_push = 1;
      cycle();
      if (last_ack) p++;
    end
    chk("fill_count", count, 8);
    chk("fill_accepted", p, 8);
    net_ack = 1;
    cycle();
    if (last_ack) p++;
    chk("full_pop_no_push", count, 7);
    cycle();
    if (last_ack) p++;
    chk("push_pop_count", count, 7);
    for (int i = 0; i < 40 && (p < 10 || sb.size() != 0); i++) begin
      gen_data = pkt(p); gen_push = (p < 10);
      cycle();
      if (last_ack) p++;
    end
    gen_push = 0;
    chk("ten_delivered", pops_m, 10);
    chk("last_seq_9", last_pop[51:40], 12'd9);

    // Sequence wrap over 4097 packets
    do_reset();
    net_ack = 1; got = 0;
    for (int i = 0; i < 4097; i++) begin
      gen_data = {$urandom(), $urandom()}; gen_push = 1;
      cycle();
      if (pops_m == 4096 && !got) begin
        chk("sent_at_4096", sent_cnt, 32'd4096);
        got = 1;
      end
    end
    gen_push = 0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) cycle();
    chk("wrap_pops", pops_m, 4097);
    chk("wrap_seq0", last_pop[51:40], 12'd0);
    chk("wrap_sent_final", sent_cnt, 32'd4097);

    // Drain on end_sim
    do_reset();
    for (int i = 0; i < 5; i++) begin
      gen_data = pkt(100 + i); gen_push = 1;
      cycle();
    end
    chk("pre_drain_count", count, 5);
    end_sim = 1; gen_push = 1; net_ack = 1;
    zero_at = -1; done_at = -1;
    for (int i = 0; i < 50 && done_at < 0; i++) begin
      cycle();
      if (sb.size() == 0 && zero_at < 0) zero_at = i;
      if (drain_done) done_at = i;
    end
    chk("drain_pops", pops_m, 5);
    chk("drain_done_seen", done_at >= 0, 1'b1);
    chk("drain_done_latency", done_at, zero_at + 1);
    gen_push = 0;

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      gen_data = pkt(200 + i); gen_push = 1;
      cycle();
    end
    gen_push = 0;
    chk("pre_rst_net_req", net_req, 1'b1);
    reset = 1;
    cycle();
    reset = 0;
    chk("mid_rst_net_req", net_req, 1'b0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_sent", sent_cnt, 0);
    chk("mid_rst_q_empty", q_empty, 1'b1);
    gen_data = 64'hE000_0000_0000_00AB; gen_push = 1; net_ack = 1;
    cycle();
    gen_push = 0;
    chk("post_rst_seq0", net_data, 64'hE1D0_0000_0000_00AB);
    cycle();
    chk("post_rst_sent", sent_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
